// File: rtl/rxpy_wordbuf.sv
// RX payload word buffer: FWFT FIFO for decoded payload words plus packet
// completion tracking (word count, CRC, length) with a post-payload flush window.
module rxpy_wordbuf #(
    parameter int DEPTH    = 8,
    parameter int FLUSH_TO = 255
) (
    input  logic                     clk_6M,
    input  logic                     rstz,
    input  logic [31:0]              rxpydin,
    input  logic                     rxpydin_valid_p,
    input  logic                     dec_py_period,
    input  logic                     dec_crcgood,
    input  logic [9:0]               dec_pylenByte,
    input  logic                     rd_req,
    input  logic                     ovf_clr,
    output logic [31:0]              rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     overflow,
    output logic                     pkt_done_p,
    output logic                     pkt_crcgood,
    output logic [8:0]               pkt_wordcnt,
    output logic [9:0]               pkt_lenByte
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
    localparam logic [7:0]    FLUSH_LIM = 8'(FLUSH_TO);
    localparam logic [8:0]    WCNT_MAX  = 9'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          rd_valid_r;
    logic          ovf_r;

    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic          drop_s;

    logic          py_prev_r;
    logic          rise_s;
    logic          fall_s;

    state_t        state_r;
    state_t        state_nxt_s;
    logic [8:0]    run_cnt_r;
    logic [8:0]    run_cnt_nxt_s;
    logic [8:0]    run_cur_s;
    logic [8:0]    pkt_cnt_val_s;
    logic [7:0]    timer_r;
    logic [7:0]    timer_nxt_s;
    logic          crc_r;
    logic          crc_nxt_s;
    logic          count_en_s;
    logic          load_pkt_s;

    logic          pkt_done_r;
    logic          pkt_crc_r;
    logic [8:0]    pkt_wcnt_r;
    logic [9:0]    pkt_len_r;

    // Handshake decode, payload-period edge detection and next occupancy
    always_comb begin
        full_s = (cnt_r == FULL_CNT);
        pop_s  = rd_req & rd_valid_r;
        // A pop frees the slot at the edge, so a full buffer can still accept
        push_s = rxpydin_valid_p & (~full_s | pop_s);
        drop_s = rxpydin_valid_p & full_s & ~pop_s;
        rise_s = dec_py_period & ~py_prev_r;
        fall_s = ~dec_py_period & py_prev_r;
        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_ONE;
            2'b01:   cnt_nxt_s = cnt_r - CNT_ONE;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Word storage; contents are not reset, only the pointers are
    always_ff @(posedge clk_6M) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= rxpydin;
        end
    end

    // Pointers, occupancy, non-empty flag and sticky overflow
    always_ff @(posedge clk_6M) begin
        if (rstz) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            cnt_r      <= CNT_ZERO;
            rd_valid_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            cnt_r      <= cnt_nxt_s;
            rd_valid_r <= (cnt_nxt_s != CNT_ZERO);
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (ovf_clr) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Packet FSM next state, running word count and completion load
    always_comb begin
        state_nxt_s   = state_r;
        run_cnt_nxt_s = run_cnt_r;
        timer_nxt_s   = timer_r;
        crc_nxt_s     = crc_r;
        load_pkt_s    = 1'b0;
        pkt_cnt_val_s = run_cnt_r;
        count_en_s    = push_s & ((state_r == ST_RECV) | (state_r == ST_FLUSH));
        if (count_en_s && (run_cnt_r != WCNT_MAX)) begin
            run_cur_s = run_cnt_r + 9'd1;
        end else begin
            run_cur_s = run_cnt_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s   = ST_RECV;
                    run_cnt_nxt_s = 9'd0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_RECV: begin
                run_cnt_nxt_s = run_cur_s;
                if (fall_s) begin
                    state_nxt_s = ST_FLUSH;
                    crc_nxt_s   = dec_crcgood;
                    timer_nxt_s = 8'd0;
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_FLUSH: begin
                // A word arriving in the completion cycle still belongs to this packet
                pkt_cnt_val_s = run_cur_s;
                if (rise_s) begin
                    state_nxt_s   = ST_RECV;
                    load_pkt_s    = 1'b1;
                    run_cnt_nxt_s = 9'd0;
                end else if (push_s || (timer_r == FLUSH_LIM)) begin
                    state_nxt_s   = ST_DONE;
                    load_pkt_s    = 1'b1;
                    run_cnt_nxt_s = run_cur_s;
                end else begin
                    state_nxt_s   = ST_FLUSH;
                    timer_nxt_s   = timer_r + 8'd1;
                    run_cnt_nxt_s = run_cur_s;
                end
            end
            ST_DONE: begin
                if (rise_s) begin
                    state_nxt_s   = ST_RECV;
                    run_cnt_nxt_s = 9'd0;
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                run_cnt_nxt_s = 9'd0;
            end
        endcase
    end

    // Packet FSM state, edge history, running count, flush timer, CRC latch
    always_ff @(posedge clk_6M) begin
        if (rstz) begin
            state_r   <= ST_IDLE;
            py_prev_r <= 1'b0;
            run_cnt_r <= 9'd0;
            timer_r   <= 8'd0;
            crc_r     <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            py_prev_r <= dec_py_period;
            run_cnt_r <= run_cnt_nxt_s;
            timer_r   <= timer_nxt_s;
            crc_r     <= crc_nxt_s;
        end
    end

    // Completed-packet result registers and end-of-packet strobe
    always_ff @(posedge clk_6M) begin
        if (rstz) begin
            pkt_done_r <= 1'b0;
            pkt_crc_r  <= 1'b0;
            pkt_wcnt_r <= 9'd0;
            pkt_len_r  <= 10'd0;
        end else begin
            pkt_done_r <= load_pkt_s;
            if (load_pkt_s) begin
                pkt_crc_r  <= crc_r;
                pkt_wcnt_r <= pkt_cnt_val_s;
                pkt_len_r  <= dec_pylenByte;
            end
        end
    end

    assign rd_data     = mem_r[rd_ptr_r];
    assign rd_valid    = rd_valid_r;
    assign fifo_cnt    = cnt_r;
    assign overflow    = ovf_r;
    assign pkt_done_p  = pkt_done_r;
    assign pkt_crcgood = pkt_crc_r;
    assign pkt_wordcnt = pkt_wcnt_r;
    assign pkt_lenByte = pkt_len_r;

endmodule

// File: tb/tb_rxpy_wordbuf.sv
// Scoreboard bench for rxpy_wordbuf: a queue-based buffer model and an
// event-rule packet model feed expected queues; a negedge monitor compares.
module tb_rxpy_wordbuf;

    localparam int DEPTH    = 8;
    localparam int FLUSH_TO = 12;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk_6M = 1'b0;
    logic          rstz;
    logic [31:0]   rxpydin;
    logic          rxpydin_valid_p;
    logic          dec_py_period;
    logic          dec_crcgood;
    logic [9:0]    dec_pylenByte;
    logic          rd_req;
    logic          ovf_clr;
    logic [31:0]   rd_data;
    logic          rd_valid;
    logic [CW-1:0] fifo_cnt;
    logic          overflow;
    logic          pkt_done_p;
    logic          pkt_crcgood;
    logic [8:0]    pkt_wordcnt;
    logic [9:0]    pkt_lenByte;

    always #5 clk_6M = ~clk_6M;

    rxpy_wordbuf #(.DEPTH(DEPTH), .FLUSH_TO(FLUSH_TO)) dut (
        .clk_6M(clk_6M), .rstz(rstz), .rxpydin(rxpydin), .rxpydin_valid_p(rxpydin_valid_p),
        .dec_py_period(dec_py_period), .dec_crcgood(dec_crcgood), .dec_pylenByte(dec_pylenByte),
        .rd_req(rd_req), .ovf_clr(ovf_clr), .rd_data(rd_data), .rd_valid(rd_valid),
        .fifo_cnt(fifo_cnt), .overflow(overflow), .pkt_done_p(pkt_done_p),
        .pkt_crcgood(pkt_crcgood), .pkt_wordcnt(pkt_wordcnt), .pkt_lenByte(pkt_lenByte)
    );

    typedef struct {
        int cyc;
        int wc;
        bit crc;
        int len;
    } pkt_t;

    pkt_t        exp_pkt_q[$];
    logic [31:0] exp_data_q[$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;
    bit mon_due;

    // reference model state
    int mdl_cnt;
    bit mdl_ovf;
    bit mdl_prev;
    bit mdl_open;
    bit mdl_flushing;
    int mdl_fall;
    int mdl_words;
    bit mdl_crc;
    int last_wc;
    bit last_crc;
    int last_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic emit_pkt();
        pkt_t p;
        p.cyc = cyc;
        p.wc  = mdl_words;
        p.crc = mdl_crc;
        p.len = int'(dec_pylenByte);
        exp_pkt_q.push_back(p);
        last_wc  = p.wc;
        last_crc = p.crc;
        last_len = p.len;
    endtask

    // Applies the rules to the inputs that were sampled at the edge just taken.
    task automatic model_update();
        int  kin;
        bit  pop, acc, drop, rise, fall;
        kin = cyc - 1;
        if (rstz) begin
            mdl_cnt = 0;
            exp_data_q.delete();
            exp_pkt_q.delete();
            mdl_ovf = 1'b0;
            mdl_prev = 1'b0;
            mdl_open = 1'b0;
            mdl_flushing = 1'b0;
            mdl_words = 0;
            last_wc = 0;
            last_crc = 1'b0;
            last_len = 0;
            return;
        end
        pop  = rd_req && (mdl_cnt > 0);
        acc  = rxpydin_valid_p && ((mdl_cnt < DEPTH) || pop);
        drop = rxpydin_valid_p && !acc;
        if (pop) mdl_cnt--;
        if (acc) begin
            mdl_cnt++;
            exp_data_q.push_back(rxpydin);
        end
        if (drop) mdl_ovf = 1'b1;
        else if (ovf_clr) mdl_ovf = 1'b0;

        rise = dec_py_period && !mdl_prev;
        fall = !dec_py_period && mdl_prev;
        mdl_prev = dec_py_period;

        if (!mdl_open) begin
            if (rise) begin
                mdl_open = 1'b1;
                mdl_flushing = 1'b0;
                mdl_words = 0;
            end
        end else begin
            if (acc && mdl_words < 511) mdl_words++;
            if (!mdl_flushing) begin
                if (fall) begin
                    mdl_flushing = 1'b1;
                    mdl_fall = kin;
                    mdl_crc = dec_crcgood;
                end
            end else if (rise) begin
                emit_pkt();
                mdl_words = 0;
                mdl_flushing = 1'b0;
            end else if (acc || (kin == mdl_fall + FLUSH_TO + 1)) begin
                emit_pkt();
                mdl_open = 1'b0;
                mdl_flushing = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_6M);
        cyc++;
        model_update();
        #1;
        rxpydin_valid_p = 1'b0;
        rd_req = 1'b0;
        ovf_clr = 1'b0;
        rstz = 1'b0;
    endtask

    task automatic drive(input bit v, input bit r);
        rxpydin_valid_p = v;
        rxpydin = $urandom;
        rd_req = r;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: compares DUT outputs to the scoreboard away from the active edge.
    always @(negedge clk_6M) begin
        if (mon_en) begin
            check("fifo_cnt", 32'(fifo_cnt), 32'(mdl_cnt));
            check("rd_valid", 32'(rd_valid), 32'(mdl_cnt != 0));
            check("overflow", 32'(overflow), 32'(mdl_ovf));
            mon_due = (exp_pkt_q.size() > 0) && (exp_pkt_q[0].cyc == cyc);
            check("pkt_done_p", 32'(pkt_done_p), 32'(mon_due));
            if (mon_due) begin
                check("done_wordcnt", 32'(pkt_wordcnt), 32'(exp_pkt_q[0].wc));
                check("done_crcgood", 32'(pkt_crcgood), 32'(exp_pkt_q[0].crc));
                check("done_lenByte", 32'(pkt_lenByte), 32'(exp_pkt_q[0].len));
                void'(exp_pkt_q.pop_front());
            end
            check("pkt_wordcnt", 32'(pkt_wordcnt), 32'(last_wc));
            check("pkt_crcgood", 32'(pkt_crcgood), 32'(last_crc));
            check("pkt_lenByte", 32'(pkt_lenByte), 32'(last_len));
            if (rd_valid && exp_data_q.size() > 0) begin
                check("rd_data", rd_data, exp_data_q[0]);
                if (rd_req) void'(exp_data_q.pop_front());
            end
        end
    end

    initial begin
        rstz = 1'b1;
        rxpydin = 32'd0;
        rxpydin_valid_p = 1'b0;
        dec_py_period = 1'b0;
        dec_crcgood = 1'b0;
        dec_pylenByte = 10'd0;
        rd_req = 1'b0;
        ovf_clr = 1'b0;
        step();
        mon_en = 1'b1;
        idle(2);

        // three pushes then three pops
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0);
        idle(2);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1);
        idle(2);

        // overfill, clear overflow, then push+pop while full
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 1'b0);
        ovf_clr = 1'b1;
        step();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
        for (int i = 0; i < DEPTH + 2; i++) drive(1'b0, 1'b1);

        // 5 words in payload, fall with CRC good, 6th word 10 cycles later
        dec_py_period = 1'b1;
        step();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
        dec_py_period = 1'b0;
        dec_crcgood = 1'b1;
        dec_pylenByte = 10'd17;
        step();
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        idle(4);

        // flush timeout, then a rising edge inside the flush window
        dec_py_period = 1'b1;
        dec_pylenByte = 10'd40;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1);
        dec_py_period = 1'b0;
        dec_crcgood = 1'b0;
        idle(FLUSH_TO + 6);
        dec_py_period = 1'b1;
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1);
        dec_py_period = 1'b0;
        dec_crcgood = 1'b1;
        idle(5);
        dec_py_period = 1'b1;
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b1);
        dec_py_period = 1'b0;
        idle(FLUSH_TO + 6);

        // reset mid-packet with four words buffered
        dec_py_period = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0);
        rstz = 1'b1;
        step();
        dec_py_period = 1'b0;
        idle(FLUSH_TO + 4);

        // running count saturates at 511
        dec_py_period = 1'b1;
        step();
        for (int i = 0; i < 515; i++) drive(1'b1, 1'b1);
        dec_py_period = 1'b0;
        idle(FLUSH_TO + 4);
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1);

        // randomized traffic
        begin
            int rd_pct = 50;
            for (int n = 0; n < 4000; n++) begin
                if (n % 200 == 0) rd_pct = int'($urandom_range(5, 95));
                if ($urandom_range(0, 29) == 0) begin
                    dec_py_period = ~dec_py_period;
                    dec_crcgood = 1'($urandom);
                    dec_pylenByte = 10'($urandom_range(0, 1023));
                end
                ovf_clr = ($urandom_range(0, 49) == 0);
                rstz = ($urandom_range(0, 999) == 0);
                drive($urandom_range(0, 2) == 0, $urandom_range(1, 100) <= rd_pct);
            end
        end
        dec_py_period = 1'b0;
        idle(FLUSH_TO + 6);
        mon_en = 1'b0;
        check("pkt_queue_drained", 32'(exp_pkt_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
